// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: shift-add multiply and restoring divide, one bit per cycle.
// Signed ops iterate on magnitudes and fix the signs in FINISH.
module mips_cpu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0]   m_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [CW-1:0]      cnt;
  logic               div_op, neg_res, neg_rem, div_zero;

  logic               zero_div_in, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  assign zero_div_in = op[1] && (rt_content == '0);
  assign rs_neg      = op[0] && rs_content[WIDTH-1];
  assign rt_neg      = op[0] && rt_content[WIDTH-1];
  assign rs_mag      = rs_neg ? -rs_content : rs_content;
  assign rt_mag      = rt_neg ? -rt_content : rt_content;

  // p_reg holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign mul_sum  = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, p_reg[WIDTH-1:1]};
  assign div_tmp  = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, m_reg};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
  assign div_next = {div_rem, p_reg[WIDTH-2:0], div_ok};
  assign prod_fix = neg_res ? -p_reg : p_reg;
  assign quo_fix  = neg_res ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -p_reg[2*WIDTH-1:WIDTH] : p_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = zero_div_in ? FINISH : CALC;
      CALC:    if (cnt == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      m_reg    <= '0;
      p_reg    <= '0;
      cnt      <= '0;
      div_op   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_op   <= op[1];
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= zero_div_in;
            cnt      <= '0;
            if (zero_div_in) begin
              m_reg <= '0;
              p_reg <= {{WIDTH{1'b0}}, rs_content};
            end else if (op[1]) begin
              m_reg <= rt_mag;
              p_reg <= {{WIDTH{1'b0}}, rs_mag};
            end else begin
              m_reg <= rs_mag;
              p_reg <= {{WIDTH{1'b0}}, rt_mag};
            end
          end else begin
            if (mthi) hi <= rs_content;
            if (mtlo) lo <= rs_content;
          end
        end
        CALC: begin
          p_reg <= div_op ? div_next : mul_next;
          cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          if (div_zero) begin
            hi <= p_reg[WIDTH-1:0];
            lo <= '1;
          end else if (div_op) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Scoreboard bench for mips_cpu_muldiv_ctrl: expected hi/lo/latency queued at issue, checked at done.
module tb_mips_cpu_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_content = '0;
  logic [31:0] rt_content = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int assert_cnt = 0;
  int fail_cnt   = 0;

  mips_cpu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_content(rs_content), .rt_content(rt_content),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference results computed with native 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] mh, output logic [31:0] ml, output int mlat);
    logic [63:0] p;
    longint      sa, sb, q, r;
    mlat = 33;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    mh = '0;
    ml = '0;
    if (o == 2'b00) begin
      p  = {32'd0, rs} * {32'd0, rt};
      mh = p[63:32];
      ml = p[31:0];
    end else if (o == 2'b01) begin
      p  = 64'(sa * sb);
      mh = p[63:32];
      ml = p[31:0];
    end else if (rt == 32'd0) begin
      mh = rs;
      ml = 32'hFFFF_FFFF;
      mlat = 1;
    end else if (o == 2'b10) begin
      ml = rs / rt;
      mh = rs % rt;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      ml = q[31:0];
      mh = r[31:0];
    end
  endfunction

  // Caller must be at a negedge; returns at the negedge after the start edge
  task automatic start_op(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat, input bit track);
    start = 1'b1;
    op = o;
    rs_content = rs;
    rt_content = rt;
    if (track) exp_q.push_back('{ehi, elo, elat});
    @(negedge clk);
    start = 1'b0;
    rs_content = $urandom;
    rt_content = $urandom;
  endtask

  task automatic wait_done(input string name, input int lat0);
    int          lat = lat0;
    logic [31:0] h0 = hi;
    logic [31:0] l0 = lo;
    bit          moved = 1'b0;
    bit          busy_bad = 1'b0;
    exp_t        e;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    assert_cnt++;
    if (done !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL %s done: got no pulse within %0d cycles, required pulse", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $display("[TB] FAIL %s scoreboard: got done with empty queue, required pending entry", name);
      return;
    end
    e = exp_q.pop_front();
    assert_cnt++;
    if (hi !== e.hi) begin fail_cnt++; $display("[TB] FAIL %s hi: got %h required %h", name, hi, e.hi); end
    assert_cnt++;
    if (lo !== e.lo) begin fail_cnt++; $display("[TB] FAIL %s lo: got %h required %h", name, lo, e.lo); end
    assert_cnt++;
    if (lat != e.lat) begin fail_cnt++; $display("[TB] FAIL %s latency: got %0d required %0d", name, lat, e.lat); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL %s busy_at_done: got %b required 0", name, busy); end
    assert_cnt++;
    if (busy_bad) begin fail_cnt++; $display("[TB] FAIL %s busy_during_op: got low required high", name); end
    assert_cnt++;
    if (moved) begin fail_cnt++; $display("[TB] FAIL %s hold: got hi/lo change before done, required hold", name); end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #11;
    assert_cnt++;
    if (hi !== 32'd0) begin fail_cnt++; $display("[TB] FAIL reset_hi: got %h required 0", hi); end
    assert_cnt++;
    if (lo !== 32'd0) begin fail_cnt++; $display("[TB] FAIL reset_lo: got %h required 0", lo); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    assert_cnt++;
    if (done !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    @(negedge clk);
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b1);
    wait_done("multu_max", 0);
    @(negedge clk);
    assert_cnt++;
    if (done !== 1'b0) begin fail_cnt++; $display("[TB] FAIL done_pulse_width: got %b required 0", done); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b1);
    wait_done("mult_neg", 0);
    start_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b1);
    wait_done("div_b2b", 0);
  endtask

  task automatic test_div_corner();
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b1);
    wait_done("div_overflow", 0);
    @(negedge clk);
    start_op(2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1, 1'b1);
    wait_done("divu_zero", 0);
  endtask

  task automatic test_ignore_while_busy();
    @(negedge clk);
    start_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1; op = 2'b00; rs_content = 32'd5; rt_content = 32'd5;
      end else if (c == 11) begin
        start = 1'b0; mthi = 1'b1; rs_content = 32'hAAAA_5555;
      end else if (c == 12) begin
        mthi = 1'b0;
      end
    end
    assert_cnt++;
    if (hi !== 32'h0000_0064) begin fail_cnt++; $display("[TB] FAIL mthi_while_busy: got %h required 00000064", hi); end
    wait_done("divu_ignore", 12);
  endtask

  task automatic test_moves();
    @(negedge clk);
    mthi = 1'b1; rs_content = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; rs_content = 32'h9ABC_DEF0;
    @(negedge clk);
    mtlo = 1'b0;
    assert_cnt++;
    if (hi !== 32'h1234_5678) begin fail_cnt++; $display("[TB] FAIL mthi: got %h required 12345678", hi); end
    assert_cnt++;
    if (lo !== 32'h9ABC_DEF0) begin fail_cnt++; $display("[TB] FAIL mtlo: got %h required 9abcdef0", lo); end
    mthi = 1'b1; mtlo = 1'b1; rs_content = 32'h0F0F_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    assert_cnt++;
    if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F) begin
      fail_cnt++; $display("[TB] FAIL mthi_mtlo_both: got %h/%h required 0f0f0f0f/0f0f0f0f", hi, lo);
    end
    mtlo = 1'b1;
    start_op(2'b10, 32'd50, 32'd5, 32'd0, 32'd10, 33, 1'b1);
    mtlo = 1'b0;
    assert_cnt++;
    if (lo !== 32'h0F0F_0F0F) begin fail_cnt++; $display("[TB] FAIL start_beats_mtlo: got %h required 0f0f0f0f", lo); end
    wait_done("divu_with_mtlo", 0);
  endtask

  task automatic test_reset_mid();
    bit stray = 1'b0;
    @(negedge clk);
    start_op(2'b01, 32'd12345, 32'hFFFF_FFF0, 32'd0, 32'd0, 33, 1'b0);
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_busy: got %b required 0", busy); end
    assert_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0) begin fail_cnt++; $display("[TB] FAIL midreset_hilo: got %h/%h required 0/0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) stray = 1'b1;
    end
    assert_cnt++;
    if (stray) begin fail_cnt++; $display("[TB] FAIL midreset_stray_done: got pulse required none"); end
    start_op(2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 33, 1'b1);
    wait_done("divu_after_reset", 0);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] rs, rt, mh, ml;
    int          mlat;
    for (int i = 0; i < 8; i++) begin
      o  = 2'($urandom_range(0, 3));
      rs = $urandom;
      rt = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) begin o = 2'b11; rt = 32'd0; end
      if (i == 6) rs = 32'hFFFF_FF00 | rs[7:0];
      model(o, rs, rt, mh, ml, mlat);
      @(negedge clk);
      start_op(o, rs, rt, mh, ml, mlat, 1'b1);
      wait_done($sformatf("random_%0d_op%0d", i, o), 0);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_div_corner();
    test_ignore_while_busy();
    test_moves();
    test_reset_mid();
    test_random();
    assert_cnt++;
    if (exp_q.size() != 0) begin fail_cnt++; $display("[TB] FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
